scanline_ctrl: RTL

- Per-frame and per-line sequencer that drives the configuration and position inputs of the scanline emulation pipeline.
- Shadows the raw scanline settings and commits them only at frame start, so a frame never mixes settings. Illegal values are sanitised on commit.
- Runs a vertical phase accumulator that produces the fractional in-source-line position (sl_rel_pos) for every output line of the scaled image.
- Sits in the PPU between the config register bank and the scanline stage, on the output video clock.

---
 rtl/scanline_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/scanline_ctrl.sv
// Frame/line sequencer for the scanline stage: shadows config at frame start and tracks vertical phase.
// Latency: commit is visible 2 cycles after VSYNC goes active; a new line position is visible 2 cycles after DE falls.
// Backpressure: none; this block follows the video timing and never stalls it.
module scanline_ctrl #(
  parameter bit VSYNC_ACT_HIGH = 1'b0,
  parameter int LCNT_W         = 11
) (
  input  logic              VCLK_i,
  input  logic              nVRST_i,
  input  logic              VSYNC_i,
  input  logic              DE_i,
  input  logic              cfg_sl_en_i,
  input  logic [7:0]        cfg_thickness_i,
  input  logic [7:0]        cfg_softening_i,
  input  logic [7:0]        cfg_strength_i,
  input  logic [4:0]        cfg_bloom_i,
  input  logic [9:0]        cfg_vinc_i,
  input  logic [7:0]        cfg_voffset_i,
  output logic              sl_en_o,
  output logic [7:0]        sl_thickness_o,
  output logic [7:0]        sl_edge_softening_o,
  output logic [7:0]        sl_strength_o,
  output logic [4:0]        sl_bloom_o,
  output logic [7:0]        sl_rel_pos_o,
  output logic [LCNT_W-1:0] line_cnt_o,
  output logic              cfg_commit_o
);

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_vs_act, r_de;
  logic                r_commit, r_pos_upd;
  logic                r_en;
  logic [7:0]          r_thick, r_soft, r_strength;
  logic [4:0]          r_bloom;
  // Only the fractional part of vinc matters because the integer carry is dropped,
  // so bit 9 is used solely to recognise the zero value.
  logic [8:0]          r_vinc;
  logic [7:0]          r_acc;
  logic [7:0]          r_pos;
  logic [LCNT_W-1:0]   r_line_cnt;

  logic                w_vs_act, w_vs_start, w_de_fall, w_advance;
  logic [7:0]          w_thick_s, w_soft_s;
  logic [8:0]          w_vinc_s;

  assign w_vs_act   = (VSYNC_i == VSYNC_ACT_HIGH);
  assign w_vs_start = w_vs_act & ~r_vs_act;
  assign w_de_fall  = r_de & ~DE_i;
  // A commit in the same cycle as a line end wins; the line advance is dropped.
  assign w_advance  = w_de_fall & (r_state == ST_RUN) & ~r_commit;

  // Register VSYNC (as active level) and DE once for edge detection; VSYNC starts "active" so a held level never commits.
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      r_vs_act <= 1'b1;
      r_de     <= 1'b0;
    end else begin
      r_vs_act <= w_vs_act;
      r_de     <= DE_i;
    end
  end

  // FSM state register.
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) r_state <= ST_WAIT;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and enable gating; RUN is only left through reset.
  always_comb begin
    w_state_nxt = r_state;
    sl_en_o     = 1'b0;
    case (r_state)
      ST_WAIT: if (w_vs_start) w_state_nxt = ST_RUN;
      ST_RUN:  sl_en_o = r_en;
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  // Sanitise raw settings on their way into the shadows.
  always_comb begin
    w_thick_s = (cfg_thickness_i > 8'h40) ? 8'h40 : cfg_thickness_i;
    w_soft_s  = 8'h08;
    case (cfg_softening_i)
      8'h80, 8'h40, 8'h20, 8'h10, 8'h08: w_soft_s = cfg_softening_i;
      default:                           w_soft_s = 8'h08;
    endcase
    w_vinc_s  = (cfg_vinc_i == 10'd0) ? 9'h100 : cfg_vinc_i[8:0];
  end

  // Commit pulse one cycle after the VSYNC edge, and the position-refresh pulse one cycle after a line advance.
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      r_commit  <= 1'b0;
      r_pos_upd <= 1'b0;
    end else begin
      r_commit  <= w_vs_start;
      r_pos_upd <= w_advance;
    end
  end

  // Shadow registers: loaded only in the commit cycle so a frame never mixes settings.
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      r_en       <= 1'b0;
      r_thick    <= 8'h00;
      r_soft     <= 8'h08;
      r_strength <= 8'h00;
      r_bloom    <= 5'h00;
      r_vinc     <= 9'h000;
    end else if (r_commit) begin
      r_en       <= cfg_sl_en_i;
      r_thick    <= w_thick_s;
      r_soft     <= w_soft_s;
      r_strength <= cfg_strength_i;
      r_bloom    <= cfg_bloom_i;
      r_vinc     <= w_vinc_s;
    end
  end

  // Phase accumulator, line counter and line-centre position.
  always_ff @(posedge VCLK_i or negedge nVRST_i) begin
    if (!nVRST_i) begin
      r_acc      <= 8'h00;
      r_pos      <= 8'h80;
      r_line_cnt <= '0;
    end else if (r_commit) begin
      r_acc      <= cfg_voffset_i;
      r_pos      <= cfg_voffset_i + w_vinc_s[8:1];
      r_line_cnt <= '0;
    end else begin
      if (w_advance) begin
        r_acc <= r_acc + r_vinc[7:0];
        if (r_line_cnt != {LCNT_W{1'b1}}) r_line_cnt <= r_line_cnt + LCNT_W'(1);
      end
      if (r_pos_upd) r_pos <= r_acc + r_vinc[8:1];
    end
  end

  assign sl_thickness_o      = r_thick;
  assign sl_edge_softening_o = r_soft;
  assign sl_strength_o       = r_strength;
  assign sl_bloom_o          = r_bloom;
  assign sl_rel_pos_o        = r_pos;
  assign line_cnt_o          = r_line_cnt;
  assign cfg_commit_o        = r_commit;

endmodule
